// File: rtl/debug_word_packer.sv
// debug_word_packer
// Buffers 32-bit debug words (PC, registers, memory, pipeline latches) in a
// small FIFO and feeds them to the UART transmitter one byte at a time,
// least-significant byte first, using the transmitter's start/done handshake.
// The debug unit can push words back-to-back while the UART paces the bytes.
//
// Optional feature: define PACKER_CHECKSUM_EN to append one extra byte per
// word, the XOR of all of that word's data bytes.
//
// Ports:
//   i_clk         system clock (clock-wizard output)
//   i_reset       synchronous, active-high reset
//   i_word_valid  push request
//   i_word        word to send
//   o_word_ready  high when the FIFO is not full
//   o_tx_start    one-cycle start pulse to the UART transmitter
//   o_tx_data     byte to transmit
//   i_tx_done     one-cycle pulse from the transmitter: byte finished
//   o_busy        high while a word is in flight or words are buffered
//   o_fifo_count  words currently buffered
//   o_overflow    sticky: a push was attempted while the FIFO was full
module debug_word_packer #(
  parameter int BITS_SIZE  = 32,
  parameter int SIZE_TRAMA = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_word_valid,
  input  logic [BITS_SIZE-1:0]          i_word,
  output logic                          o_word_ready,
  output logic                          o_tx_start,
  output logic [SIZE_TRAMA-1:0]         o_tx_data,
  input  logic                          i_tx_done,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int N_BYTES = BITS_SIZE / SIZE_TRAMA;
`ifdef PACKER_CHECKSUM_EN
  localparam int LAST_IDX = N_BYTES;
`else
  localparam int LAST_IDX = N_BYTES - 1;
`endif
  localparam int IDX_W = $clog2(N_BYTES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  state_t                state;
  state_t                state_next;
  logic [BITS_SIZE-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;
  logic                  last_byte;
  logic [BITS_SIZE-1:0]  shift_reg;
  logic [IDX_W-1:0]      byte_idx;

  // Ready comes from the registered count only, so a push while full is
  // rejected even if a pop happens on the same edge.
  assign o_word_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push         = i_word_valid && o_word_ready;
  assign last_byte    = (byte_idx == IDX_W'(LAST_IDX));
  // The head stays in the FIFO until its final byte completes, so the word
  // being sent is never overwritten by a later push.
  assign pop          = (state == WAIT) && i_tx_done && last_byte;

  // FIFO storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_word;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (i_word_valid && !o_word_ready) begin
        o_overflow <= 1'b1;
      end
    end
  end

`ifdef PACKER_CHECKSUM_EN
  logic [SIZE_TRAMA-1:0] head_xor;
  logic [SIZE_TRAMA-1:0] chk_reg;

  // XOR of all data bytes of the FIFO head, captured together with the word.
  always_comb begin
    head_xor = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      head_xor = head_xor ^ fifo_mem[rd_ptr][b*SIZE_TRAMA +: SIZE_TRAMA];
    end
  end
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; i_tx_done only matters while waiting on a byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = LOAD;
      LOAD:    state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT:    if (i_tx_done) state_next = last_byte ? IDLE : SEND;
      default: state_next = IDLE;
    endcase
  end

  // Shift register and byte index: load the head, then shift one byte
  // down after every completed byte that is not the last one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      shift_reg <= '0;
      byte_idx  <= '0;
`ifdef PACKER_CHECKSUM_EN
      chk_reg   <= '0;
`endif
    end else if (state == LOAD) begin
      shift_reg <= fifo_mem[rd_ptr];
      byte_idx  <= '0;
`ifdef PACKER_CHECKSUM_EN
      chk_reg   <= head_xor;
`endif
    end else if ((state == WAIT) && i_tx_done && !last_byte) begin
      byte_idx <= byte_idx + IDX_W'(1);
`ifdef PACKER_CHECKSUM_EN
      if (byte_idx == IDX_W'(N_BYTES - 1)) begin
        shift_reg <= {{(BITS_SIZE-SIZE_TRAMA){1'b0}}, chk_reg};
      end else begin
        shift_reg <= shift_reg >> SIZE_TRAMA;
      end
`else
      shift_reg <= shift_reg >> SIZE_TRAMA;
`endif
    end
  end

  assign o_tx_start   = (state == SEND);
  assign o_tx_data    = shift_reg[SIZE_TRAMA-1:0];
  assign o_busy       = (state != IDLE) || (count != '0);
  assign o_fifo_count = count;

endmodule

// File: tb/tb_debug_word_packer.sv
// tb_debug_word_packer
// Scoreboard bench for debug_word_packer: a reference model turns every
// accepted word into its expected byte sequence and tracks FIFO occupancy;
// a monitor compares every start pulse and the status outputs against it.
module tb_debug_word_packer;

  localparam int DEPTH = 4;
`ifdef PACKER_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        i_clk;
  logic        i_reset;
  logic        i_word_valid;
  logic [31:0] i_word;
  logic        o_word_ready;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_busy;
  logic [2:0]  o_fifo_count;
  logic        o_overflow;

  logic done_rsp;
  logic done_poke;
  assign i_tx_done = done_rsp | done_poke;

  debug_word_packer #(.BITS_SIZE(32), .SIZE_TRAMA(8), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_word_valid(i_word_valid), .i_word(i_word),
    .o_word_ready(o_word_ready), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .i_tx_done(i_tx_done), .o_busy(o_busy), .o_fifo_count(o_fifo_count),
    .o_overflow(o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int  model_count = 0;
  bit  model_ovf = 0;
  int  bytes_in_word = 0;
  int  since_done = 0;
  int  expect_gap = 0;
  bit  mon_en = 0;
  int  reset_gen = 0;
  bit  stall = 0;
  bit  rand_delay = 0;
  int  resp_delay = 10;
  int  start_seen = 0;

  bit  m_acc;
  bit  m_pop;
  int  m_old;
  logic [7:0] m_chk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference model: FIFO occupancy, overflow and the expected byte stream,
  // updated from the inputs at every clock edge.
  always @(posedge i_clk) begin
    if (i_reset) begin
      exp_q.delete();
      model_count   = 0;
      model_ovf     = 0;
      bytes_in_word = 0;
      expect_gap    = 0;
    end else begin
      m_old = model_count;
      m_acc = i_word_valid && (model_count < DEPTH);
      if (i_word_valid && !m_acc) model_ovf = 1;
      m_pop = 0;
      if (done_rsp) begin
        if (bytes_in_word == NB - 1) begin
          m_pop = 1;
          bytes_in_word = 0;
        end else begin
          bytes_in_word++;
        end
      end
      if (m_acc) begin
        m_chk = 8'h00;
        for (int b = 0; b < 4; b++) begin
          exp_q.push_back(i_word[8*b +: 8]);
          m_chk = m_chk ^ i_word[8*b +: 8];
        end
`ifdef PACKER_CHECKSUM_EN
        exp_q.push_back(m_chk);
`endif
      end
      model_count = m_old + int'(m_acc) - int'(m_pop);
      if (done_rsp) begin
        since_done = 0;
        expect_gap = m_pop ? ((model_count > 0) ? 3 : 0) : 1;
      end else if (m_acc && m_old == 0) begin
        since_done = 0;
        expect_gap = 3;
      end
    end
  end

  // Monitor: every start pulse pops one expected byte; status outputs are
  // compared against the model on every falling edge.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (since_done < 100000) since_done++;
      if (o_tx_start) begin
        start_seen++;
        got_q.push_back(o_tx_data);
        if (exp_q.size() == 0) begin
          failNow($sformatf("unexpected_start data=0x%0h", o_tx_data));
        end else begin
          checkOutput("tx_byte", {24'h0, o_tx_data}, {24'h0, exp_q.pop_front()});
        end
        if (expect_gap != 0) begin
          checkOutput("start_gap", since_done, expect_gap);
          expect_gap = 0;
        end
      end
      checkOutput("fifo_count", {29'h0, o_fifo_count}, model_count);
      checkOutput("word_ready", {31'h0, o_word_ready}, {31'h0, model_count < DEPTH});
      checkOutput("busy", {31'h0, o_busy}, {31'h0, model_count != 0});
      checkOutput("overflow", {31'h0, o_overflow}, {31'h0, model_ovf});
    end
  end

  // UART transmitter stand-in: answers each start with a done pulse after
  // a delay; abandons the answer if a reset happened meanwhile.
  int rsp_gen;
  int rsp_dly;
  always begin
    @(negedge i_clk);
    if (o_tx_start && mon_en) begin
      rsp_gen = reset_gen;
      rsp_dly = rand_delay ? int'($urandom_range(1, 8)) : resp_delay;
      repeat (rsp_dly) @(posedge i_clk);
      while (stall) @(posedge i_clk);
      #1;
      if (rsp_gen == reset_gen) begin
        done_rsp = 1'b1;
        @(posedge i_clk);
        #1 done_rsp = 1'b0;
      end
    end
  end

  task automatic syncEdge();
    @(posedge i_clk);
    #1;
  endtask

  // Present one word for exactly one edge; call right after a rising edge.
  task automatic applyStimulus(input logic [31:0] w);
    i_word_valid = 1'b1;
    i_word = w;
    @(posedge i_clk);
    #1;
    i_word_valid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_reset = 1'b1;
    reset_gen++;
    @(negedge i_clk);
    checkOutput("rst_tx_start", {31'h0, o_tx_start}, 0);
    checkOutput("rst_tx_data", {24'h0, o_tx_data}, 0);
    checkOutput("rst_ready", {31'h0, o_word_ready}, 1);
    checkOutput("rst_count", {29'h0, o_fifo_count}, 0);
    checkOutput("rst_busy", {31'h0, o_busy}, 0);
    checkOutput("rst_overflow", {31'h0, o_overflow}, 0);
    i_reset = 1'b0;
    syncEdge();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((model_count != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge i_clk);
      n++;
    end
    if (n >= 3000) failNow({name, "_drain_timeout"});
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic addWord(inout logic [7:0] q[$], input logic [31:0] w);
    logic [7:0] c;
    c = 8'h00;
    for (int b = 0; b < 4; b++) begin
      q.push_back(w[8*b +: 8]);
      c = c ^ w[8*b +: 8];
    end
`ifdef PACKER_CHECKSUM_EN
    q.push_back(c);
`endif
  endtask

  task automatic checkBytes(input string name, input logic [7:0] expl[$]);
    checkOutput({name, "_len"}, got_q.size(), expl.size());
    for (int i = 0; i < expl.size(); i++) begin
      if (i < got_q.size()) checkOutput($sformatf("%s_b%0d", name, i), {24'h0, got_q[i]}, {24'h0, expl[i]});
    end
  endtask

  logic [7:0] expl[$];
  int saved_starts;
  int n_wait;

  initial begin
    i_reset = 1'b1;
    i_word_valid = 1'b0;
    i_word = '0;
    done_rsp = 1'b0;
    done_poke = 1'b0;
    repeat (3) @(posedge i_clk);
    doReset();
    mon_en = 1'b1;

    // Single word, fixed 10-cycle transmitter.
    $display("[TB] single word 0xDEADBEEF");
    got_q.delete();
    applyStimulus(32'hDEADBEEF);
    waitDrain("t1");
    expl.delete();
    expl.push_back(8'hEF); expl.push_back(8'hBE); expl.push_back(8'hAD); expl.push_back(8'hDE);
`ifdef PACKER_CHECKSUM_EN
    expl.push_back(8'h22);
`endif
    checkBytes("t1", expl);
    @(negedge i_clk);
    checkOutput("t1_busy_end", {31'h0, o_busy}, 0);
    checkOutput("t1_count_end", {29'h0, o_fifo_count}, 0);
    syncEdge();

    // Three words back-to-back.
    $display("[TB] three back-to-back words");
    got_q.delete();
    resp_delay = 4;
    applyStimulus(32'h00000001);
    applyStimulus(32'h12345678);
    applyStimulus(32'hFFFFFFFF);
    waitDrain("t2");
    expl.delete();
    addWord(expl, 32'h00000001);
    addWord(expl, 32'h12345678);
    addWord(expl, 32'hFFFFFFFF);
    checkBytes("t2", expl);
    checkOutput("t2_overflow", {31'h0, o_overflow}, 0);

    // Done pulses while idle and during SEND must be ignored.
    $display("[TB] spurious done pulses");
    got_q.delete();
    done_poke = 1'b1;
    syncEdge();
    done_poke = 1'b0;
    syncEdge();
    applyStimulus(32'hA1B2C3D4);
    n_wait = 0;
    do begin
      @(negedge i_clk);
      n_wait++;
    end while (!o_tx_start && n_wait < 50);
    if (n_wait >= 50) failNow("t3_start_timeout");
    done_poke = 1'b1;
    @(posedge i_clk);
    #1 done_poke = 1'b0;
    waitDrain("t3");
    expl.delete();
    addWord(expl, 32'hA1B2C3D4);
    checkBytes("t3", expl);

    // Stalled transmitter: fill the FIFO, fifth push overflows.
    $display("[TB] overflow with stalled transmitter");
    got_q.delete();
    stall = 1'b1;
    applyStimulus(32'h11111111);
    applyStimulus(32'h22222222);
    applyStimulus(32'h33333333);
    applyStimulus(32'h44444444);
    applyStimulus(32'h55555555);
    @(negedge i_clk);
    checkOutput("t4_ready_full", {31'h0, o_word_ready}, 0);
    checkOutput("t4_count_full", {29'h0, o_fifo_count}, 4);
    checkOutput("t4_overflow_set", {31'h0, o_overflow}, 1);
    stall = 1'b0;
    syncEdge();
    waitDrain("t4");
    expl.delete();
    addWord(expl, 32'h11111111);
    addWord(expl, 32'h22222222);
    addWord(expl, 32'h33333333);
    addWord(expl, 32'h44444444);
    checkBytes("t4", expl);
    checkOutput("t4_overflow_sticky", {31'h0, o_overflow}, 1);

    // Reset in the middle of a word with a second word queued.
    $display("[TB] reset mid-word");
    doReset();
    resp_delay = 10;
    saved_starts = start_seen;
    applyStimulus(32'hCAFEF00D);
    applyStimulus(32'h0BADC0DE);
    n_wait = 0;
    while (start_seen < saved_starts + 2 && n_wait < 200) begin
      @(negedge i_clk);
      n_wait++;
    end
    if (n_wait >= 200) failNow("t5_byte1_timeout");
    @(negedge i_clk);
    doReset();
    saved_starts = start_seen;
    repeat (40) @(posedge i_clk);
    #1;
    checkOutput("t5_no_start_after_reset", start_seen, saved_starts);
    got_q.delete();
    applyStimulus(32'h5A5AA5A5);
    waitDrain("t5");
    expl.delete();
    addWord(expl, 32'h5A5AA5A5);
    checkBytes("t5", expl);

    // Randomized traffic against the model.
    $display("[TB] randomized traffic");
    rand_delay = 1'b1;
    for (int k = 0; k < 24; k++) begin
      n_wait = 0;
      while (model_count >= DEPTH && n_wait < 500) begin
        syncEdge();
        n_wait++;
      end
      if (n_wait >= 500) failNow("t6_space_timeout");
      applyStimulus($urandom);
      repeat ($urandom_range(0, 3)) syncEdge();
    end
    waitDrain("t6");
    checkOutput("t6_queue_empty", exp_q.size(), 0);
    checkOutput("t6_overflow", {31'h0, o_overflow}, 0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
